// File: rtl/prog_memory.sv
// Program memory with a burst loader, a 1-cycle registered fetch port and a
// registered debug mirror of a single fixed word.
// The loader is a three-state FSM (IDLE -> LOAD -> DONE -> IDLE).
// Fetches are only served while the loader is idle.
// Both read ports return pre-write contents when a word is read and written
// in the same cycle.
module prog_memory #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int DEBUG_ADDR = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              loading,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] debug_data
);

    localparam int                DEPTH  = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] DBG_A  = ADDR_W'(DEBUG_ADDR);
    localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    // One extra bit so a full-depth burst (load_len == 0) is representable.
    logic [ADDR_W:0]     rem_q, rem_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   fetch_data_q;
    logic                fetch_valid_q;
    logic [DATA_W-1:0]   debug_data_q;

    logic                accept;
    logic                fetch_go;

    // A word is accepted only while in LOAD; an aborted burst (reset) stops writes at once.
    assign accept   = (state_q == ST_LOAD) && load_valid;
    assign fetch_go = fetch_en && (state_q == ST_IDLE);

    assign load_ready  = (state_q == ST_LOAD);
    assign loading     = (state_q == ST_LOAD);
    assign load_done   = (state_q == ST_DONE);
    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign debug_data  = debug_data_q;

    // Loader state, write pointer and remaining-word count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

    // Loader next-state logic: start latches the burst, accepts advance it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = load_base;
                    rem_d   = (load_len == '0) ? REM_FULL : {1'b0, load_len};
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage array; deliberately not reset so loaded code survives a reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[ptr_q] <= load_data;
        end
    end

    // Registered fetch port; fetches during LOAD/DONE are dropped and data holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            fetch_valid_q <= fetch_go;
            if (fetch_go) begin
                fetch_data_q <= mem_q[fetch_addr];
            end
        end
    end

    // Debug mirror of the fixed word, refreshed every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            debug_data_q <= '0;
        end else begin
            debug_data_q <= mem_q[DBG_A];
        end
    end

endmodule

// File: tb/tb_prog_memory.sv
// Self-checking bench for prog_memory: a transaction-level model tracks
// the memory image and expected outputs, a compare process checks every
// cycle, and directed scenarios pin exact values by hand.
module tb_prog_memory;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int DEBUG_ADDR = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic [ADDR_W-1:0] load_base = '0;
    logic [ADDR_W-1:0] load_len = '0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_ready;
    logic              load_done;
    logic              loading;
    logic              fetch_en = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic [DATA_W-1:0] debug_data;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model: memory image (-1 = never written), burst progress, expected regs.
    int m_mem [256];
    bit m_init = 1'b0;
    int m_mode = 0;   // 0 idle, 1 loading, 2 done pulse
    int m_addr = 0;
    int m_left = 0;
    int exp_fd = -1;
    int exp_fv = 0;
    int exp_dbg = -1;

    prog_memory #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEBUG_ADDR(DEBUG_ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .load_base  (load_base),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .loading    (loading),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_valid(fetch_valid),
        .debug_data (debug_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of the specified transactions.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            if (!m_init) begin
                for (int i = 0; i < 256; i++) m_mem[i] <= -1;
                m_init <= 1'b1;
            end
            m_mode  <= 0;
            m_addr  <= 0;
            m_left  <= 0;
            exp_fd  <= 0;
            exp_fv  <= 0;
            exp_dbg <= 0;
        end else begin
            exp_dbg <= m_mem[DEBUG_ADDR];
            if (fetch_en && m_mode == 0) begin
                exp_fv <= 1;
                exp_fd <= m_mem[fetch_addr];
            end else begin
                exp_fv <= 0;
            end
            case (m_mode)
                0: if (load_start) begin
                    m_mode <= 1;
                    m_addr <= load_base;
                    m_left <= (load_len == 0) ? 256 : int'(load_len);
                end
                1: if (load_valid) begin
                    m_mem[m_addr] <= load_data;
                    m_addr <= (m_addr + 1) % 256;
                    m_left <= m_left - 1;
                    if (m_left == 1) m_mode <= 2;
                end
                default: m_mode <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", load_ready, int'(m_mode == 1));
            check("loading", loading, int'(m_mode == 1));
            check("done", load_done, int'(m_mode == 2));
            check("fvalid", fetch_valid, exp_fv);
            if (exp_fd >= 0) check("fdata", fetch_data, exp_fd);
            if (exp_dbg >= 0) check("debug", debug_data, exp_dbg);
        end
    end

    task automatic fetch(input logic [ADDR_W-1:0] a, input int exp);
        fetch_en = 1'b1;
        fetch_addr = a;
        tick();
        fetch_en = 1'b0;
        check("fetch_v_lit", fetch_valid, 1);
        check("fetch_d_lit", fetch_data, exp);
    endtask

    task automatic burst(input logic [ADDR_W-1:0] base, input int n, input int d0, input int step);
        load_start = 1'b1;
        load_base = base;
        load_len = ADDR_W'(n);
        tick();
        load_start = 1'b0;
        check("burst_loading", loading, 1);
        for (int k = 0; k < n; k++) begin
            load_valid = 1'b1;
            load_data = DATA_W'(d0 + k * step);
            tick();
        end
        load_valid = 1'b0;
        check("burst_done", load_done, 1);
        tick();
        check("burst_done_end", load_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        #3 reset = 1'b1;
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_fdata", fetch_data, 0);
        check("rst_fvalid", fetch_valid, 0);
        check("rst_debug", debug_data, 0);
        check("rst_ready", load_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_loading", loading, 0);
        reset = 1'b0;
        tick();

        // Full-depth burst (len 0): exactly 256 accepts, 257th ignored.
        load_start = 1'b1;
        load_base = 8'h00;
        load_len = 8'h00;
        tick();
        load_start = 1'b0;
        acc = 0;
        for (int n = 0; n < 300 && acc < 256; n++) begin
            load_valid = 1'b1;
            load_data = DATA_W'(16'h5000 + acc);
            if (load_ready) acc++;
            tick();
        end
        check("fill_count", acc, 256);
        check("fill_done", load_done, 1);
        load_data = 16'hDEAD;
        check("fill_257_ready", load_ready, 0);
        tick();
        load_valid = 1'b0;
        check("fill_done_end", load_done, 0);
        tick();
        fetch(8'h00, 16'h5000);
        fetch(8'hFF, 16'h50FF);

        // Basic burst and fetch-back.
        burst(8'h10, 3, 16'hA001, 1);
        fetch(8'h11, 16'hA002);
        fetch(8'h10, 16'hA001);
        fetch(8'h12, 16'hA003);

        // Pointer wrap.
        burst(8'hFE, 4, 16'h1111, 16'h1111);
        fetch(8'hFE, 16'h1111);
        fetch(8'hFF, 16'h2222);
        fetch(8'h00, 16'h3333);
        fetch(8'h01, 16'h4444);

        // Debug word: old on write edge, new one edge later.
        load_start = 1'b1;
        load_base = 8'h01;
        load_len = 8'h01;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 16'hBEEF;
        check("dbg_before", debug_data, 16'h4444);
        tick();
        load_valid = 1'b0;
        check("dbg_write_edge", debug_data, 16'h4444);
        check("dbg_done", load_done, 1);
        tick();
        check("dbg_after", debug_data, 16'hBEEF);

        // Fetch held high across a burst over the fetched word.
        fetch_en = 1'b1;
        fetch_addr = 8'h20;
        load_start = 1'b1;
        load_base = 8'h20;
        load_len = 8'h02;
        tick();
        load_start = 1'b0;
        check("hold_e0_v", fetch_valid, 1);
        check("hold_e0_d", fetch_data, 16'h5020);
        load_valid = 1'b1;
        load_data = 16'hC001;
        tick();
        check("hold_e1_v", fetch_valid, 0);
        check("hold_e1_d", fetch_data, 16'h5020);
        load_data = 16'hC002;
        tick();
        load_valid = 1'b0;
        check("hold_e2_v", fetch_valid, 0);
        check("hold_e2_done", load_done, 1);
        tick();
        check("hold_e3_v", fetch_valid, 0);
        check("hold_e3_d", fetch_data, 16'h5020);
        tick();
        fetch_en = 1'b0;
        check("hold_e4_v", fetch_valid, 1);
        check("hold_e4_d", fetch_data, 16'hC001);
        tick();

        // Reset mid-burst after 2 of 5 words.
        load_start = 1'b1;
        load_base = 8'h40;
        load_len = 8'h05;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data = 16'h9001;
        tick();
        load_data = 16'h9002;
        tick();
        load_data = 16'h9003;
        #2 reset = 1'b1;
        #1;
        check("abort_fdata", fetch_data, 0);
        check("abort_fvalid", fetch_valid, 0);
        check("abort_debug", debug_data, 0);
        check("abort_ready", load_ready, 0);
        check("abort_loading", loading, 0);
        check("abort_done", load_done, 0);
        tick();
        tick();
        reset = 1'b0;
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_no_done", load_done, 0);
        end
        fetch(8'h40, 16'h9001);
        fetch(8'h41, 16'h9002);
        fetch(8'h42, 16'h5042);
        fetch(8'h43, 16'h5043);
        fetch(8'h44, 16'h5044);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_memory.md
PROG_MEMORY -- requirements
Module: prog_memory

Interface
REQ-001 Parameter DATA_W, default 16, instruction word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width; depth = 2**ADDR_W words.
REQ-003 Parameter DEBUG_ADDR, default 1, fixed word address mirrored on debug_data.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 load_start  in  1  one-cycle request to begin a burst load.
REQ-007 load_base  in  ADDR_W  first write address, sampled with load_start.
REQ-008 load_len  in  ADDR_W  burst word count, sampled with load_start; 0 means 2**ADDR_W.
REQ-009 load_valid  in  1  load_data holds a word to write.
REQ-010 load_data  in  DATA_W  word to write.
REQ-011 load_ready  out  1  block accepts a load word this cycle.
REQ-012 load_done  out  1  one-cycle pulse after the final burst word is written.
REQ-013 loading  out  1  high while a burst is in progress.
REQ-014 fetch_en  in  1  fetch request.
REQ-015 fetch_addr  in  ADDR_W  fetch address.
REQ-016 fetch_data  out  DATA_W  registered fetch result.
REQ-017 fetch_valid  out  1  fetch_data is valid this cycle.
REQ-018 debug_data  out  DATA_W  registered copy of mem[DEBUG_ADDR].

Function
REQ-019 Storage SHALL be a 2**ADDR_W x DATA_W array; contents SHALL NOT be cleared by reset.
REQ-020 FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-021 IDLE -> LOAD on load_start; the block SHALL latch ptr = load_base and remaining = load_len (0 maps to 2**ADDR_W).
REQ-022 In LOAD, load_ready = 1 and loading = 1; in IDLE and DONE both SHALL be 0.
REQ-023 In LOAD, each edge with load_valid && load_ready SHALL write mem[ptr] = load_data, increment ptr modulo 2**ADDR_W (wraps from 2**ADDR_W-1 to 0), and decrement remaining.
REQ-024 LOAD -> DONE on the edge that accepts the word bringing remaining to 0.
REQ-025 DONE SHALL assert load_done for exactly one cycle, then go to IDLE.
REQ-026 load_start in LOAD or DONE SHALL be ignored.
REQ-027 load_valid outside LOAD SHALL be ignored, with no write.
REQ-028 A cycle with load_valid = 0 in LOAD SHALL hold ptr and remaining unchanged; the burst has no timeout.
REQ-029 Fetch latency SHALL be 1 cycle: fetch_en at edge N gives fetch_data = mem[fetch_addr] and fetch_valid = 1 after edge N+1.
REQ-030 A fetch sampled while the state is LOAD or DONE SHALL be dropped: fetch_valid = 0 and fetch_data holds its previous value.
REQ-031 With fetch_en = 0, fetch_valid SHALL be 0 and fetch_data SHALL hold.
REQ-032 debug_data SHALL update every cycle from mem[DEBUG_ADDR].
REQ-033 On a read and a write to the same word in one cycle, every read port SHALL return the pre-write (old) contents.

Reset
REQ-034 While reset = 1, the FSM SHALL be IDLE and ptr = remaining = 0.
REQ-035 While reset = 1, fetch_data = 0, fetch_valid = 0, debug_data = 0, load_ready = 0, load_done = 0 and loading = 0.
REQ-036 Reset asserted mid-burst SHALL abort the burst: no further writes and no load_done pulse; words already written SHALL be retained.

Verification
REQ-037 load_start, base 0x10, len 3, data 0xA001/0xA002/0xA003 with valid held high -> writes at 0x10..0x12, load_done high 1 cycle after the third accept; then fetch 0x11 -> 0xA002 one cycle later with fetch_valid = 1.
REQ-038 base 0xFE, len 4, data 0x1111..0x4444 -> writes at 0xFE, 0xFF, 0x00, 0x01 (wrap); fetch each address back and check.
REQ-039 len 0 with default ADDR_W -> exactly 256 words accepted before load_done; a 257th valid word is not written.
REQ-040 Burst writing 0xBEEF to DEBUG_ADDR = 1 -> debug_data still shows the old value on the write edge and shows 0xBEEF on the following edge.
REQ-041 fetch_en held high during a burst -> fetch_valid = 0 for every LOAD and DONE cycle; a same-cycle read of the word being written returns old data.
REQ-042 reset asserted after 2 of 5 words -> all outputs 0 immediately, state IDLE, no load_done; the 2 written words read back intact and words 3-5 keep their prior contents.
